vga_sync_rx: RTL

- Receive-side counterpart of the VGA output path: decodes a 640x480@60 VGA stream (hs, vs, 12-bit RGB) back into pixel coordinates, data-enable and frame markers.
- Sits on the 100 MHz CLK domain and samples on a one-in-four pixel enable (25 MHz).
- Used for loopback self-check of the game display and for capturing external VGA sources.
- Verifies sync timing, and declares lock only after consecutive well-formed frames.

---
 rtl/vga_sync_rx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - VGA sync receiver: decodes hs/vs/rgb into pixel coordinates, de and frame lock
// Optional FRAME_SUM_EN adds frame_sum, the 16-bit sum of the previous locked frame's active pixels.

module vga_sync_rx #(
   parameter int H_TOTAL     = 800,
   parameter int H_SYNC      = 96,
   parameter int H_START     = 144,
   parameter int H_ACTIVE    = 640,
   parameter int V_TOTAL     = 525,
   parameter int V_SYNC      = 2,
   parameter int V_START     = 35,
   parameter int V_ACTIVE    = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        pix_ce,
   input  logic        vga_hs,
   input  logic        vga_vs,
   input  logic [11:0] vga_rgb,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        de,
   output logic [11:0] rgb_out,
   output logic        frame_start,
   output logic        locked,
`ifdef FRAME_SUM_EN
   output logic [7:0]  err_cnt,
   output logic [15:0] frame_sum
`else
   output logic [7:0]  err_cnt
`endif
);

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
   localparam logic [9:0] H_BEG    = 10'(H_START);
   localparam logic [9:0] H_END    = 10'(H_START + H_ACTIVE);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
   localparam logic [9:0] V_BEG    = 10'(V_START);
   localparam logic [9:0] V_END    = 10'(V_START + V_ACTIVE);
   localparam logic [7:0] LOCK_N   = 8'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

   state_t      state, state_nx;
   logic [7:0]  good, good_nx;
   logic        hs_s1, hs_s2, vs_s1, vs_s2;
   logic [11:0] rgb_s1, rgb_s2;
   logic        hs_d, vs_line;
   logic [9:0]  h, v, h_nx, v_nx, vs_cnt;
   logic        hs_rise, hs_fall, f_start, vs_end;
   logic        viol_line, viol_frame, viol;
   logic        locked_c, de_c, fs_c;
   logic [9:0]  pix_x_c, pix_y_c;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         hs_s1  <= 1'b0;
         hs_s2  <= 1'b0;
         vs_s1  <= 1'b0;
         vs_s2  <= 1'b0;
         rgb_s1 <= '0;
         rgb_s2 <= '0;
      end else begin
         hs_s1  <= vga_hs;
         hs_s2  <= hs_s1;
         vs_s1  <= vga_vs;
         vs_s2  <= vs_s1;
         rgb_s1 <= vga_rgb;
         rgb_s2 <= rgb_s1;
      end
   end

   // vs_line remembers vs at the previous line start, so a frame starts on the first line with vs high
   assign hs_rise = hs_s2 & ~hs_d;
   assign hs_fall = ~hs_s2 & hs_d;
   assign f_start = hs_rise & vs_s2 & ~vs_line;
   assign vs_end  = hs_rise & ~vs_s2 & vs_line;
   assign h_nx    = hs_rise ? '0 : h + 10'd1;
   assign v_nx    = hs_rise ? (f_start ? '0 : v + 10'd1) : v;

   assign viol_line  = (hs_rise && h != H_LAST) || (!hs_rise && h == H_LAST) ||
                       (hs_fall && (h + 10'd1) != H_SYNC_W);
   assign viol_frame = (f_start && v != V_LAST) || (vs_end && vs_cnt != V_SYNC_W);
   assign viol       = (state != SEARCH) && (viol_line || viol_frame);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         hs_d    <= 1'b0;
         vs_line <= 1'b0;
         h       <= '0;
         v       <= '0;
         vs_cnt  <= '0;
      end else if (pix_ce) begin
         hs_d <= hs_s2;
         h    <= h_nx;
         v    <= v_nx;
         if (hs_rise) begin
            vs_line <= vs_s2;
            if (f_start)
               vs_cnt <= 10'd1;
            else if (vs_s2)
               vs_cnt <= vs_cnt + 10'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= SEARCH;
         good  <= '0;
      end else begin
         state <= state_nx;
         good  <= good_nx;
      end
   end

   // A violation in the same update as a frame start wins; that frame is not counted
   always_comb begin
      state_nx = state;
      good_nx  = good;
      if (pix_ce) begin
         case (state)
            SEARCH: if (f_start) begin
               state_nx = TRACK;
               good_nx  = '0;
            end
            TRACK: if (viol) begin
               state_nx = SEARCH;
            end else if (f_start) begin
               good_nx = good + 8'd1;
               if (good_nx == LOCK_N)
                  state_nx = LOCKED;
            end
            LOCKED: if (viol) state_nx = SEARCH;
            default: state_nx = SEARCH;
         endcase
      end
   end

   always_comb begin
      locked_c = (state_nx == LOCKED);
      de_c     = locked_c && h_nx >= H_BEG && h_nx < H_END && v_nx >= V_BEG && v_nx < V_END;
      fs_c     = pix_ce && f_start && locked_c;
      pix_x_c  = de_c ? h_nx - H_BEG : '0;
      pix_y_c  = de_c ? v_nx - V_BEG : '0;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pix_x       <= '0;
         pix_y       <= '0;
         de          <= 1'b0;
         rgb_out     <= '0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
         err_cnt     <= '0;
      end else begin
         frame_start <= fs_c;
         if (pix_ce) begin
            pix_x   <= pix_x_c;
            pix_y   <= pix_y_c;
            de      <= de_c;
            rgb_out <= de_c ? rgb_s2 : '0;
            locked  <= locked_c;
            if (state == LOCKED && viol && err_cnt != 8'hFF)
               err_cnt <= err_cnt + 8'd1;
         end
      end
   end

`ifdef FRAME_SUM_EN
   logic [15:0] sum_acc;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sum_acc   <= '0;
         frame_sum <= '0;
      end else if (pix_ce) begin
         if (fs_c) begin
            frame_sum <= sum_acc;
            sum_acc   <= de_c ? {4'h0, rgb_s2} : '0;
         end else if (de_c) begin
            sum_acc <= sum_acc + {4'h0, rgb_s2};
         end
      end
   end
`endif

endmodule
